// File: rtl/pll_rst_sequencer_if.sv
// rtl/pll_rst_sequencer_if.sv - PLL lock/restart inputs and sequencer status outputs
interface pll_rst_sequencer_if;
  logic       i_pll_locked;
  logic       i_restart;
  logic       o_pll_rst;
  logic       o_sys_nrst;
  logic       o_locked_stable;
  logic       o_fail;
  logic [2:0] o_retry_cnt;
  logic [7:0] o_lost_cnt;

  modport master (
    output i_pll_locked,
    output i_restart,
    input  o_pll_rst,
    input  o_sys_nrst,
    input  o_locked_stable,
    input  o_fail,
    input  o_retry_cnt,
    input  o_lost_cnt
  );

  modport slave (
    input  i_pll_locked,
    input  i_restart,
    output o_pll_rst,
    output o_sys_nrst,
    output o_locked_stable,
    output o_fail,
    output o_retry_cnt,
    output o_lost_cnt
  );
endinterface

// File: rtl/pll_rst_sequencer.sv
// rtl/pll_rst_sequencer.sv - PLL reset pulse, lock qualification and system reset release
// Runs on the reference clock; retries a PLL that never locks and re-sequences on lock loss.
module pll_rst_sequencer #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 125000,
  parameter int STABLE_CYC       = 1024,
  parameter int MAX_RETRY        = 4
) (
  input logic                 i_clk,
  input logic                 i_nrst,
  pll_rst_sequencer_if.slave  bus
);

  localparam int MAX_A = (RST_PULSE_CYC > STABLE_CYC) ? RST_PULSE_CYC : STABLE_CYC;
  localparam int MAX_P = (LOCK_TIMEOUT_CYC > MAX_A) ? LOCK_TIMEOUT_CYC : MAX_A;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST   = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       RETRY_MAX  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e           state_q;
  logic             sync1_q;
  logic             lock_s_q;
  logic [CNT_W-1:0] pulse_cnt_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [CNT_W-1:0] stb_cnt_q;
  logic             pll_rst_q;
  logic             sys_nrst_q;
  logic             locked_stable_q;
  logic             fail_q;
  logic [2:0]       retry_cnt_q;
  logic [7:0]       lost_cnt_q;

  logic [CNT_W-1:0] tmo_cnt_d;
  logic [CNT_W-1:0] stb_cnt_d;
  logic [CNT_W-1:0] pulse_cnt_d;
  logic [2:0]       retry_cnt_d;
  logic [7:0]       lost_cnt_d;
  logic             timeout_d;
  logic             stable_done_d;

  always_comb begin
    tmo_cnt_d     = tmo_cnt_q + CNT_ONE;
    stb_cnt_d     = stb_cnt_q + CNT_ONE;
    pulse_cnt_d   = pulse_cnt_q + CNT_ONE;
    retry_cnt_d   = retry_cnt_q + 3'd1;
    lost_cnt_d    = (lost_cnt_q == 8'hFF) ? lost_cnt_q : lost_cnt_q + 8'd1;
    timeout_d     = (tmo_cnt_q == TMO_LAST);
    stable_done_d = lock_s_q && (stb_cnt_q == STB_LAST);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q         <= S_PLL_RST;
      sync1_q         <= 1'b0;
      lock_s_q        <= 1'b0;
      pulse_cnt_q     <= '0;
      tmo_cnt_q       <= '0;
      stb_cnt_q       <= '0;
      pll_rst_q       <= 1'b1;
      sys_nrst_q      <= 1'b0;
      locked_stable_q <= 1'b0;
      fail_q          <= 1'b0;
      retry_cnt_q     <= 3'd0;
      lost_cnt_q      <= 8'd0;
    end else begin
      // i_pll_locked is asynchronous to i_clk
      sync1_q  <= bus.i_pll_locked;
      lock_s_q <= sync1_q;

      unique case (state_q)
        S_PLL_RST: begin
          if (pulse_cnt_q == PULSE_LAST) begin
            state_q     <= S_WAIT_LOCK;
            pll_rst_q   <= 1'b0;
            pulse_cnt_q <= '0;
            tmo_cnt_q   <= '0;
          end else begin
            pulse_cnt_q <= pulse_cnt_d;
          end
        end

        S_WAIT_LOCK: begin
          tmo_cnt_q <= tmo_cnt_d;
          if (timeout_d) begin
            retry_cnt_q <= retry_cnt_d;
            pll_rst_q   <= 1'b1;
            pulse_cnt_q <= '0;
            if (retry_cnt_d == RETRY_MAX) begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= S_PLL_RST;
            end
          end else if (lock_s_q) begin
            state_q   <= S_STABLE;
            stb_cnt_q <= '0;
          end
        end

        S_STABLE: begin
          tmo_cnt_q <= tmo_cnt_d;
          // Completion outranks a coincident timeout
          if (stable_done_d) begin
            state_q         <= S_RUN;
            sys_nrst_q      <= 1'b1;
            locked_stable_q <= 1'b1;
            retry_cnt_q     <= 3'd0;
          end else if (timeout_d) begin
            retry_cnt_q <= retry_cnt_d;
            pll_rst_q   <= 1'b1;
            pulse_cnt_q <= '0;
            if (retry_cnt_d == RETRY_MAX) begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= S_PLL_RST;
            end
          end else if (!lock_s_q) begin
            // tmo_cnt keeps running so a chattering lock still times out
            state_q   <= S_WAIT_LOCK;
            stb_cnt_q <= '0;
          end else begin
            stb_cnt_q <= stb_cnt_d;
          end
        end

        S_RUN: begin
          if (!lock_s_q) begin
            state_q         <= S_PLL_RST;
            sys_nrst_q      <= 1'b0;
            locked_stable_q <= 1'b0;
            pll_rst_q       <= 1'b1;
            pulse_cnt_q     <= '0;
            lost_cnt_q      <= lost_cnt_d;
          end
        end

        S_FAIL: begin
          if (bus.i_restart) begin
            state_q     <= S_PLL_RST;
            fail_q      <= 1'b0;
            retry_cnt_q <= 3'd0;
            pulse_cnt_q <= '0;
          end
        end

        default: begin
          state_q         <= S_PLL_RST;
          pll_rst_q       <= 1'b1;
          sys_nrst_q      <= 1'b0;
          locked_stable_q <= 1'b0;
          fail_q          <= 1'b0;
          pulse_cnt_q     <= '0;
        end
      endcase
    end
  end

  assign bus.o_pll_rst       = pll_rst_q;
  assign bus.o_sys_nrst      = sys_nrst_q;
  assign bus.o_locked_stable = locked_stable_q;
  assign bus.o_fail          = fail_q;
  assign bus.o_retry_cnt     = retry_cnt_q;
  assign bus.o_lost_cnt      = lost_cnt_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// tb/tb_pll_rst_sequencer.sv - directed/randomized checks of pll_rst_sequencer against timing rules
module tb_pll_rst_sequencer;

  localparam int RP       = 4;
  localparam int TMO      = 100;
  localparam int STB      = 8;
  localparam int MR       = 3;
  localparam int REL_LAT  = 2 + STB + 1;
  localparam int DROP_LAT = 3;
  localparam int LOSSES   = 300;

  localparam int W_PRST = 0;
  localparam int W_SYS  = 1;
  localparam int W_FAIL = 2;
  localparam int W_STAB = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lost_exp = 0;

  pll_rst_sequencer_if bus ();

  pll_rst_sequencer #(
    .RST_PULSE_CYC   (RP),
    .LOCK_TIMEOUT_CYC(TMO),
    .STABLE_CYC      (STB),
    .MAX_RETRY       (MR)
  ) dut (
    .i_clk (clk),
    .i_nrst(nrst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int which);
    case (which)
      W_PRST:  return bus.o_pll_rst;
      W_SYS:   return bus.o_sys_nrst;
      W_FAIL:  return bus.o_fail;
      default: return bus.o_locked_stable;
    endcase
  endfunction

  // Number of cycles until the selected output leaves val (capped at limit)
  task automatic run_len(input int which, input logic val, input int limit, output int n);
    n = 0;
    while (sig(which) === val && n < limit) begin
      step(1);
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pll_rst"},  bus.o_pll_rst, 1);
    check({tag, ".sys_nrst"}, bus.o_sys_nrst, 0);
    check({tag, ".stable"},   bus.o_locked_stable, 0);
    check({tag, ".fail"},     bus.o_fail, 0);
    check({tag, ".retry"},    bus.o_retry_cnt, 0);
    check({tag, ".lost"},     bus.o_lost_cnt, 0);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    bus.i_pll_locked = 1'b0;
    bus.i_restart = 1'b0;
    lost_exp = 0;
    step(2);
    nrst = 1'b1;
  endtask

  // Called just after reset release with lock low: pulse, lock rise, release after REL_LAT
  task automatic seq_basic(input string tag, input int rise_after);
    int n;
    run_len(W_PRST, 1'b1, 50, n);
    check({tag, ".pulse_len"}, n, RP);
    step(rise_after - RP);
    bus.i_pll_locked = 1'b1;
    step(REL_LAT - 1);
    check({tag, ".sys_early"}, bus.o_sys_nrst, 0);
    step(1);
    check({tag, ".sys_rise"}, bus.o_sys_nrst, 1);
    check({tag, ".stable"},   bus.o_locked_stable, 1);
    check({tag, ".retry"},    bus.o_retry_cnt, 0);
    check({tag, ".pll_rst"},  bus.o_pll_rst, 0);
  endtask

  initial begin
    int n, n2, d, h, l;
    bus.i_pll_locked = 1'b0;
    bus.i_restart = 1'b0;

    // Reset value appears without any clock edge
    #2 nrst = 1'b0;
    #1 check_reset_vals("reset0");
    step(2);
    nrst = 1'b1;
    seq_basic("t1", 20);

    // Chattering lock restarts the stability window
    for (int it = 0; it < 4; it++) begin
      do_reset();
      run_len(W_PRST, 1'b1, 50, n);
      check("t2.pulse_len", n, RP);
      d = $urandom_range(0, 10);
      h = $urandom_range(1, 7);
      l = $urandom_range(1, 3);
      step(d);
      bus.i_pll_locked = 1'b1;
      step(h);
      bus.i_pll_locked = 1'b0;
      step(l);
      bus.i_pll_locked = 1'b1;
      step(REL_LAT - (h + l));
      check("t2.no_early_release", bus.o_sys_nrst, 0);
      step(h + l - 1);
      check("t2.sys_before", bus.o_sys_nrst, 0);
      step(1);
      check("t2.sys_rise", bus.o_sys_nrst, 1);
    end

    // One timeout, then lock during the second pulse: retry count clears in RUN
    do_reset();
    run_len(W_PRST, 1'b1, 50, n);
    check("t3a.pulse_len", n, RP);
    run_len(W_PRST, 1'b0, 300, n);
    check("t3a.timeout_gap", n, TMO);
    check("t3a.retry", bus.o_retry_cnt, 1);
    bus.i_pll_locked = 1'b1;
    run_len(W_SYS, 1'b0, 100, n);
    check("t3a.relock_lat", n, RP + 1 + STB);
    check("t3a.retry_clear", bus.o_retry_cnt, 0);

    // Lock never arrives: MR pulses then permanent failure
    do_reset();
    for (int k = 1; k <= MR; k++) begin
      run_len(W_PRST, 1'b1, 50, n);
      check("t3.pulse_len", n, RP);
      run_len(W_PRST, 1'b0, 300, n);
      check("t3.timeout_gap", n, TMO);
      check("t3.retry", bus.o_retry_cnt, k);
    end
    check("t3.fail", bus.o_fail, 1);
    check("t3.sys", bus.o_sys_nrst, 0);
    step(50);
    check("t3.pll_rst_stuck", bus.o_pll_rst, 1);
    check("t3.fail_held", bus.o_fail, 1);
    check("t3.retry_held", bus.o_retry_cnt, MR);

    // Restart from failure
    bus.i_restart = 1'b1;
    step(1);
    bus.i_restart = 1'b0;
    check("t5.fail_clear", bus.o_fail, 0);
    check("t5.retry_clear", bus.o_retry_cnt, 0);
    check("t5.pll_rst", bus.o_pll_rst, 1);
    run_len(W_PRST, 1'b1, 50, n);
    check("t5.pulse_len", n, RP);
    bus.i_pll_locked = 1'b1;
    step(REL_LAT - 1);
    check("t5.sys_early", bus.o_sys_nrst, 0);
    step(1);
    check("t5.sys_rise", bus.o_sys_nrst, 1);

    // Restart is ignored in RUN
    bus.i_restart = 1'b1;
    step(1);
    bus.i_restart = 1'b0;
    step(3);
    check("t5.run_sys", bus.o_sys_nrst, 1);
    check("t5.run_stable", bus.o_locked_stable, 1);
    check("t5.run_pll_rst", bus.o_pll_rst, 0);
    check("t5.run_fail", bus.o_fail, 0);

    // First loss of lock in detail
    bus.i_pll_locked = 1'b0;
    step(DROP_LAT - 1);
    check("t4.sys_still_high", bus.o_sys_nrst, 1);
    step(1);
    lost_exp = lost_exp + 1;
    check("t4.sys_fall", bus.o_sys_nrst, 0);
    check("t4.stable_fall", bus.o_locked_stable, 0);
    check("t4.lost", bus.o_lost_cnt, lost_exp);
    check("t4.pll_rst", bus.o_pll_rst, 1);
    run_len(W_PRST, 1'b1, 50, n);
    check("t4.pulse_len", n, RP);
    bus.i_pll_locked = 1'b1;
    step(REL_LAT - 1);
    check("t4.sys_early", bus.o_sys_nrst, 0);
    step(1);
    check("t4.sys_rise", bus.o_sys_nrst, 1);

    // Many losses with random low widths; counter saturates
    for (int i = 1; i < LOSSES; i++) begin
      bus.i_pll_locked = 1'b0;
      l = $urandom_range(1, 3);
      step(l);
      bus.i_pll_locked = 1'b1;
      run_len(W_SYS, 1'b1, 10, n);
      run_len(W_SYS, 1'b0, 60, n2);
      lost_exp = (lost_exp < 255) ? lost_exp + 1 : 255;
      check("t4.cycle_bounded", (n < 10) && (n2 < 60), 1);
      check("t4.lost_model", bus.o_lost_cnt, lost_exp);
    end
    check("t4.lost_saturated", bus.o_lost_cnt, 255);

    // Async reset in the middle of S_STABLE
    do_reset();
    run_len(W_PRST, 1'b1, 50, n);
    bus.i_pll_locked = 1'b1;
    step(5);
    #2 nrst = 1'b0;
    #1 check_reset_vals("t6.stable");
    step(1);
    bus.i_pll_locked = 1'b0;
    lost_exp = 0;
    step(1);
    nrst = 1'b1;
    seq_basic("t6a", 20);

    // Record one loss, then async reset in the middle of S_RUN
    bus.i_pll_locked = 1'b0;
    step(2);
    bus.i_pll_locked = 1'b1;
    run_len(W_SYS, 1'b1, 10, n);
    run_len(W_SYS, 1'b0, 60, n2);
    check("t6.lost_before", bus.o_lost_cnt, 1);
    step(3);
    #2 nrst = 1'b0;
    #1 check_reset_vals("t6.run");
    step(1);
    bus.i_pll_locked = 1'b0;
    step(1);
    nrst = 1'b1;
    seq_basic("t6b", $urandom_range(RP, 30));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
